// File: rtl/imm_pkg.sv
// Shared definitions for the pipelined immediate generator.
//   immsrc_e : immediate format selector, encodings match the decode-stage control bus
//   INSTR_W  : raw instruction width
package imm_pkg;

  localparam int INSTR_W = 32;

  typedef enum logic [2:0] {
    IMM_I   = 3'b000,
    IMM_S   = 3'b001,
    IMM_U   = 3'b010,
    IMM_Z   = 3'b011,
    IMM_SH  = 3'b100,
    IMM_B   = 3'b101,
    IMM_J   = 3'b110,
    IMM_ILL = 3'b111
  } immsrc_e;

endpackage : imm_pkg

// File: rtl/imm_decode.sv
// Purely combinational immediate decoder, shared with the compressed-instruction expander.
// Ports:
//   instr_i   : raw 32-bit instruction
//   immsrc_i  : immediate format selector
//   imm_o     : sign-/zero-extended immediate, XLEN wide
//   illegal_o : selector was the reserved encoding (imm_o forced to 0)
module imm_decode
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [INSTR_W-1:0] instr_i,
  input  immsrc_e            immsrc_i,
  output logic [XLEN-1:0]    imm_o,
  output logic               illegal_o
);

  // Every format is first assembled as a 32-bit value; sign-extending formats
  // carry their sign in bit 31 so a single widening step serves both XLENs.
  logic [31:0] raw;
  logic        sext;

  // The opcode field never contributes to an immediate.
  logic        unused_opcode;
  assign unused_opcode = ^instr_i[6:0];

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
    raw       = '0;
    sext      = 1'b0;
    illegal_o = 1'b0;
    case (immsrc_i)
      IMM_I: begin
        raw  = {{20{instr_i[31]}}, instr_i[31:20]};
        sext = 1'b1;
      end
      IMM_S: begin
        raw  = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
        sext = 1'b1;
      end
      IMM_B: begin
        raw  = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
        sext = 1'b1;
      end
      IMM_U: begin
        raw  = {instr_i[31:12], 12'h000};
        sext = 1'b1;
      end
      IMM_J: begin
        raw  = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
        sext = 1'b1;
      end
      IMM_Z: begin
        raw = {27'b0, instr_i[19:15]};
      end
      IMM_SH: begin
        // RV64 shift amounts use bit 25; on RV32 that bit belongs to funct7.
        raw = (XLEN == 64) ? {26'b0, instr_i[25:20]} : {27'b0, instr_i[24:20]};
      end
      default: begin
        illegal_o = 1'b1;
      end
    endcase
    imm_o = sext ? XLEN'($signed(raw)) : XLEN'(raw);
  end

endmodule : imm_decode

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator between the instruction register and ID/EX.
// A 2-entry skid buffer (output register + skid register) lets decode stall
// without losing immediates while keeping ready_o free of any path from ready_i.
// Ports:
//   clk, rst       : rising-edge clock, asynchronous active-high reset
//   valid_i/ready_o: input handshake for instr_i, immsrc_i, tag_i
//   valid_o/ready_i: output handshake for immext_o, tag_o, illegal_o
//   illegal_cnt_o  : saturating count of accepted illegal-selector entries
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5,
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               valid_i,
  output logic               ready_o,
  input  logic [INSTR_W-1:0] instr_i,
  input  logic [2:0]         immsrc_i,
  input  logic [TAG_W-1:0]   tag_i,
  output logic               valid_o,
  input  logic               ready_i,
  output logic [XLEN-1:0]    immext_o,
  output logic [TAG_W-1:0]   tag_o,
  output logic               illegal_o,
  output logic [CNT_W-1:0]   illegal_cnt_o
);

  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $fatal(1, "imm_gen_pipe: XLEN must be 32 or 64");
  end

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [TAG_W-1:0] tag;
    logic             ill;
  } entry_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  entry_t           new_entry;
  entry_t           out_q, out_d;
  entry_t           skid_q, skid_d;
  logic             out_valid_q, out_valid_d;
  logic             skid_valid_q, skid_valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept;
  logic             retire;

  imm_decode #(.XLEN(XLEN)) u_decode (
    .instr_i   (instr_i),
    .immsrc_i  (immsrc_e'(immsrc_i)),
    .imm_o     (new_entry.imm),
    .illegal_o (new_entry.ill)
  );
  assign new_entry.tag = tag_i;

  // Readiness depends only on stored state and reset.
  assign ready_o = !rst && !skid_valid_q;
  assign accept  = valid_i && ready_o;
  assign retire  = out_valid_q && ready_i;

  always_comb begin
    out_d        = out_q;
    out_valid_d  = out_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    cnt_d        = cnt_q;

    if (retire || !out_valid_q) begin
      // Output slot is free this edge: the older skid entry has priority.
      // An accept cannot coincide with a full skid since ready_o is low then.
      if (skid_valid_q) begin
        out_d        = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        out_d       = new_entry;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (accept) begin
      // Output stalled: park the new entry in the skid register.
      skid_d       = new_entry;
      skid_valid_d = 1'b1;
    end

    if (accept && new_entry.ill && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // NOTE: the data registers are reset along with the valid flags because the held output values are architecturally visible as zero after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q        <= '0;
      out_valid_q  <= 1'b0;
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so all flops update together from pre-edge values.
      out_q        <= out_d;
      out_valid_q  <= out_valid_d;
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
      cnt_q        <= cnt_d;
    end
  end

  assign valid_o       = out_valid_q;
  assign immext_o      = out_q.imm;
  assign tag_o         = out_q.tag;
  assign illegal_o     = out_q.ill;
  assign illegal_cnt_o = cnt_q;

endmodule : imm_gen_pipe
